spi_alu_gen2: RTL and testbench
===============================

SPI_ALU_GEN2 -- requirements
Module: spi_alu_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal 8..64.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sclk/nss/mosi; legal 2..3.
REQ-003 SHALL have clock  input  1  system clock; all logic on posedge clock.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have sclk  input  1  SPI clock, asynchronous to clock, idle low (mode 0).
REQ-006 SHALL have nss  input  1  SPI frame select, active-low.
REQ-007 SHALL have mosi  input  1  serial data in, MSB first.
REQ-008 SHALL have miso  output  1  serial data out, MSB first.
REQ-009 SHALL have busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have done  output  1  one-cycle pulse when a result is latched.
REQ-011 SHALL have last_result  output  WIDTH  most recent latched result.
REQ-012 SHALL have last_flags  output  4  most recent flags {N,V,C,Z}.

Function
REQ-013 SHALL pass sclk, nss and mosi through SYNC_STAGES flops; edges are detected on the synchronized sclk only.
REQ-014 SHALL sample mosi on each synchronized sclk rising edge and update miso on each falling edge.
REQ-015 SHALL use frame order: opcode (4 b), A (WIDTH b), B (WIDTH b), then transmit result (WIDTH b) and flags (4 b, N first).
REQ-016 SHALL implement states IDLE, RX_OP, RX_A, RX_B, EXEC, TX, WAIT_NSS.
REQ-017 IDLE->RX_OP SHALL occur when synchronized nss is low; RX_OP->RX_A after bit 4; RX_A->RX_B after bit WIDTH; RX_B->EXEC after bit WIDTH.
REQ-018 EXEC SHALL last exactly 1 cycle: latch result and flags, pulse done, load the TX shift register with {result, flags}, and drive its MSB onto miso; then go to TX.
REQ-019 TX SHALL shift on each falling edge; after WIDTH+4 falling edges it SHALL go to WAIT_NSS with miso=0.
REQ-020 WAIT_NSS SHALL ignore sclk and return to IDLE only when synchronized nss is high.
REQ-021 Synchronized nss high in RX_OP/RX_A/RX_B/TX SHALL abort to IDLE next cycle, with no done and no change to last_result/last_flags.
REQ-022 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL, 7 SHR, 8 SAR, 9 ROL, A ROR, B SLT (signed, result 0/1), C SLTU (result 0/1).
REQ-023 Shift/rotate amount SHALL be B[$clog2(WIDTH)-1:0]; amount 0 returns A unchanged.
REQ-024 C SHALL be the ADD carry-out, or the SUB borrow (1 when A<B unsigned); 0 for all other ops.
REQ-025 V SHALL be signed overflow for ADD/SUB; 0 otherwise.
REQ-026 Z SHALL be (result==0) and N SHALL be result[WIDTH-1] for every opcode.
REQ-027 Opcodes D-F SHALL give result 0 with flags Z=1 and N=V=C=0; done still pulses.
REQ-028 miso SHALL be 0 outside EXEC/TX.
REQ-029 Master sclk high and low phases SHALL each be at least SYNC_STAGES+2 clock periods; behaviour for faster sclk is not required.

Reset
REQ-030 On reset: state IDLE, miso=0, busy=0, done=0, last_result=0, last_flags=0, all counters, shift registers and synchronizer flops cleared.
REQ-031 Reset asserted mid-frame SHALL abort immediately; after release, the block SHALL wait in IDLE and a new frame requires nss high then low (frame starts only from IDLE with counters at 0).

Verification
REQ-032 WIDTH=32, ADD A=0xFFFFFFFF B=0x00000001 -> result 0x00000000, flags N0 V0 C1 Z1, done one pulse.
REQ-033 WIDTH=32, SUB A=0x80000000 B=0x00000001 -> result 0x7FFFFFFF, N0 V1 C0 Z0.
REQ-034 WIDTH=8, ROR A=0x81 B=0x01 -> 0xC0; SAR A=0x80 B=0x0F (amount 7) -> 0xFF, N1.
REQ-035 WIDTH=32, SLT A=0xFFFFFFFF B=0x00000001 -> 0x00000001; SLTU same operands -> 0x00000000, Z1.
REQ-036 nss raised after 10 bits of A -> IDLE, no done, last_result unchanged; next full frame completes correctly.
REQ-037 Opcode 0xE -> result 0, flags 0001; extra sclk pulses in WAIT_NSS -> miso stays 0 and no new frame until nss toggles high.

Source files
------------

// File: rtl/spi_alu_gen2_if.sv
// SPI pins of the serial ALU: mode-0 clock, active-low frame select, MSB-first data.
interface spi_alu_gen2_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;

  modport master (output sclk, output nss, output mosi, input miso);
  modport slave  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/spi_alu_gen2.sv
// SPI-attached ALU: receive opcode/A/B over SPI mode 0, execute, shift back {result, flags}.
//   state    | meaning
//   IDLE     | waiting for nss low (after nss has been seen high since reset)
//   RX_OP    | shifting in 4-bit opcode
//   RX_A     | shifting in operand A
//   RX_B     | shifting in operand B
//   EXEC     | one cycle: latch result/flags, pulse done, load TX shifter
//   TX       | shifting out {result, flags} on sclk falling edges
//   WAIT_NSS | frame finished, sclk ignored until nss returns high
module spi_alu_gen2 #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  spi_alu_gen2_if.slave     spi,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  last_result,
  output logic [3:0]        last_flags
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 5);
  localparam logic [CW-1:0] OP_LAST  = CW'(3);
  localparam logic [CW-1:0] OPR_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TX_LAST  = CW'(WIDTH + 3);

  typedef enum logic [2:0] {IDLE, RX_OP, RX_A, RX_B, EXEC, TX, WAIT_NSS} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, nss_sync, mosi_sync;
  logic                   sclk_s, nss_s, mosi_s, sclk_d;
  logic                   sclk_rise, sclk_fall, armed;
  logic [CW-1:0]          cnt;
  logic [3:0]             op_reg;
  logic [WIDTH-1:0]       a_reg, b_reg;
  logic [WIDTH+3:0]       tx_sr;
  logic                   miso_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      nss_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi.nss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign nss_s     = nss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  // ALU
  logic [SW-1:0]    amt;
  logic [SW:0]      amt_inv;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  assign amt     = b_reg[SW-1:0];
  assign amt_inv = (SW+1)'(WIDTH) - {1'b0, amt};
  assign sum     = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff    = {1'b0, a_reg} - {1'b0, b_reg};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_reg)
      4'h0: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      4'h1: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
      end
      4'h2: alu_res = a_reg & b_reg;
      4'h3: alu_res = a_reg | b_reg;
      4'h4: alu_res = a_reg ^ b_reg;
      4'h5: alu_res = ~a_reg;
      4'h6: alu_res = a_reg << amt;
      4'h7: alu_res = a_reg >> amt;
      4'h8: alu_res = WIDTH'($signed(a_reg) >>> amt);
      // amt_inv equals WIDTH when amt is 0, so the wrap term vanishes
      4'h9: alu_res = (a_reg << amt) | (a_reg >> amt_inv);
      4'hA: alu_res = (a_reg >> amt) | (a_reg << amt_inv);
      4'hB: alu_res = {{(WIDTH-1){1'b0}}, $signed(a_reg) < $signed(b_reg)};
      4'hC: alu_res = {{(WIDTH-1){1'b0}}, a_reg < b_reg};
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_res[WIDTH-1], alu_v, alu_c, alu_res == '0};

  // FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (armed && !nss_s) state_nxt = RX_OP;
      RX_OP:    if (nss_s) state_nxt = IDLE;
                else if (sclk_rise && cnt == OP_LAST) state_nxt = RX_A;
      RX_A:     if (nss_s) state_nxt = IDLE;
                else if (sclk_rise && cnt == OPR_LAST) state_nxt = RX_B;
      RX_B:     if (nss_s) state_nxt = IDLE;
                else if (sclk_rise && cnt == OPR_LAST) state_nxt = EXEC;
      EXEC:     state_nxt = TX;
      TX:       if (nss_s) state_nxt = IDLE;
                else if (sclk_fall && cnt == TX_LAST) state_nxt = WAIT_NSS;
      WAIT_NSS: if (nss_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // A frame may only start once nss has been seen high, so a reset mid-frame cannot resume it
  always_ff @(posedge clock or posedge reset) begin
    if (reset)              armed <= 1'b0;
    else if (nss_s)         armed <= 1'b1;
    else if (state != IDLE) armed <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      tx_sr       <= '0;
      miso_q      <= 1'b0;
      done        <= 1'b0;
      last_result <= '0;
      last_flags  <= '0;
    end else begin
      done <= (state == EXEC);
      if (state != state_nxt)
        cnt <= '0;
      else if ((sclk_rise && (state == RX_OP || state == RX_A || state == RX_B)) ||
               (sclk_fall && state == TX))
        cnt <= cnt + 1'b1;

      if (sclk_rise) begin
        if (state == RX_OP) op_reg <= {op_reg[2:0], mosi_s};
        if (state == RX_A)  a_reg  <= {a_reg[WIDTH-2:0], mosi_s};
        if (state == RX_B)  b_reg  <= {b_reg[WIDTH-2:0], mosi_s};
      end

      if (state == EXEC) begin
        last_result <= alu_res;
        last_flags  <= alu_flags;
        tx_sr       <= {alu_res, alu_flags};
        miso_q      <= alu_res[WIDTH-1];
      end else if (state_nxt != TX) begin
        miso_q <= 1'b0;
      end else if (sclk_fall) begin
        tx_sr  <= {tx_sr[WIDTH+2:0], 1'b0};
        miso_q <= tx_sr[WIDTH+2];
      end
    end
  end

  assign spi.miso = miso_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_alu_gen2.sv
// Directed bench for spi_alu_gen2: 32-bit and 8-bit instances driven by a bit-banged SPI master.
module tb_spi_alu_gen2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b0;
  logic        sclk_v = 1'b0;
  logic        nss_v  = 1'b1;
  logic        mosi_v = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          dcnt32 = 0;
  int          dcnt8  = 0;

  logic        busy32, done32, busy8, done8;
  logic [31:0] last_result32;
  logic [7:0]  last_result8;
  logic [3:0]  last_flags32, last_flags8;

  spi_alu_gen2_if if32 ();
  spi_alu_gen2_if if8 ();

  assign if32.sclk = sel ? 1'b0 : sclk_v;
  assign if32.nss  = sel ? 1'b1 : nss_v;
  assign if32.mosi = sel ? 1'b0 : mosi_v;
  assign if8.sclk  = sel ? sclk_v : 1'b0;
  assign if8.nss   = sel ? nss_v  : 1'b1;
  assign if8.mosi  = sel ? mosi_v : 1'b0;

  spi_alu_gen2 #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .clock(clock), .reset(reset), .spi(if32), .busy(busy32), .done(done32),
    .last_result(last_result32), .last_flags(last_flags32));

  spi_alu_gen2 #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clock(clock), .reset(reset), .spi(if8), .busy(busy8), .done(done8),
    .last_result(last_result8), .last_flags(last_flags8));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (done32 === 1'b1) dcnt32++;
    if (done8 === 1'b1)  dcnt8++;
  end

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_miso();
    return sel ? if8.miso : if32.miso;
  endfunction

  function automatic logic cur_busy();
    return sel ? busy8 : busy32;
  endfunction

  function automatic int cur_dcnt();
    return sel ? dcnt8 : dcnt32;
  endfunction

  task automatic pulse(input logic b, output logic bo);
    mosi_v = b;
    repeat (6) @(negedge clock);
    sclk_v = 1'b1;
    repeat (6) @(negedge clock);
    bo = cur_miso();
    sclk_v = 1'b0;
  endtask

  // Shift in op/A/B, then collect WIDTH+4 bits sampled before each falling edge
  task automatic frame(input int w, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output logic [67:0] rx);
    logic bo;
    rx = '0;
    nss_v = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 3; i >= 0; i--) pulse(op[i], bo);
    for (int i = w - 1; i >= 0; i--) pulse(a[i], bo);
    for (int i = w - 1; i >= 0; i--) pulse(b[i], bo);
    rx = {rx[66:0], bo};
    for (int k = 0; k < w + 3; k++) begin
      pulse(1'b0, bo);
      rx = {rx[66:0], bo};
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic do_op(input string tag, input int w, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic [3:0] ef, input logic release_nss);
    logic [67:0] rx;
    logic [63:0] mask;
    int d0;
    d0 = cur_dcnt();
    frame(w, op, a, b, rx);
    mask = (64'd1 << w) - 64'd1;
    check({tag, "_tx_res"}, (rx >> 4) & {4'h0, mask}, er);
    check({tag, "_tx_flags"}, rx[3:0], ef);
    check({tag, "_last_res"}, sel ? {60'h0, last_result8} : {36'h0, last_result32}, er);
    check({tag, "_last_flags"}, sel ? last_flags8 : last_flags32, ef);
    check({tag, "_done_cnt"}, cur_dcnt() - d0, 1);
    check({tag, "_miso_after"}, cur_miso(), 0);
    check({tag, "_busy_wait"}, cur_busy(), 1);
    if (release_nss) begin
      nss_v = 1'b1;
      repeat (8) @(negedge clock);
      check({tag, "_busy_idle"}, cur_busy(), 0);
    end
  endtask

  initial begin
    logic bo;
    logic any;
    int d0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    check("rst_busy32", busy32, 0);
    check("rst_done32", done32, 0);
    check("rst_res32", last_result32, 0);
    check("rst_flags32", last_flags32, 0);
    check("rst_miso32", if32.miso, 0);
    check("rst_busy8", busy8, 0);
    check("rst_res8", last_result8, 0);

    sel = 1'b0;
    do_op("add32", 32, 4'h0, 64'hFFFF_FFFF, 64'h1, 64'h0, 4'h3, 1'b1);
    do_op("sub32", 32, 4'h1, 64'h8000_0000, 64'h1, 64'h7FFF_FFFF, 4'h4, 1'b1);
    do_op("sltu32", 32, 4'hC, 64'hFFFF_FFFF, 64'h1, 64'h0, 4'h1, 1'b1);
    do_op("slt32", 32, 4'hB, 64'hFFFF_FFFF, 64'h1, 64'h1, 4'h0, 1'b1);

    // Abort after 10 bits of A
    d0 = dcnt32;
    nss_v = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 14; i++) pulse(i[0], bo);
    nss_v = 1'b1;
    repeat (8) @(negedge clock);
    check("abort_busy", busy32, 0);
    check("abort_done", dcnt32 - d0, 0);
    check("abort_res", last_result32, 32'h1);
    check("abort_flags", last_flags32, 4'h0);
    do_op("xor32", 32, 4'h4, 64'hF0F0_F0F0, 64'h0FF0_0FF0, 64'hFF00_FF00, 4'h8, 1'b1);

    // Reserved opcode, then extra sclk pulses while parked in WAIT_NSS
    do_op("opE32", 32, 4'hE, 64'h1234_5678, 64'h9ABC_DEF0, 64'h0, 4'h1, 1'b0);
    d0 = dcnt32;
    any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, bo);
      any = any | bo | if32.miso;
    end
    repeat (8) @(negedge clock);
    check("wait_miso", any, 0);
    check("wait_busy", busy32, 1);
    check("wait_done", dcnt32 - d0, 0);
    check("wait_res", last_result32, 32'h0);
    nss_v = 1'b1;
    repeat (8) @(negedge clock);
    check("wait_release", busy32, 0);

    sel = 1'b1;
    repeat (4) @(negedge clock);
    do_op("ror8", 8, 4'hA, 64'h81, 64'h01, 64'hC0, 4'h8, 1'b1);
    do_op("sar8", 8, 4'h8, 64'h80, 64'h0F, 64'hFF, 4'h8, 1'b1);
    do_op("add8", 8, 4'h0, 64'h7F, 64'h01, 64'h80, 4'hC, 1'b1);
    do_op("shl8_amt0", 8, 4'h6, 64'h5A, 64'h08, 64'h5A, 4'h0, 1'b1);

    // Reset mid-frame, nss held low across release
    sel = 1'b0;
    repeat (4) @(negedge clock);
    nss_v = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 10; i++) pulse(1'b1, bo);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midrst_busy", busy32, 0);
    check("midrst_res", last_result32, 0);
    check("midrst_flags", last_flags32, 0);
    check("midrst_miso", if32.miso, 0);
    reset = 1'b0;
    d0 = dcnt32;
    for (int i = 0; i < 10; i++) begin
      pulse(1'b1, bo);
      if (i == 5) check("midrst_hold_busy", busy32, 0);
    end
    repeat (8) @(negedge clock);
    check("midrst_no_frame", busy32, 0);
    check("midrst_no_done", dcnt32 - d0, 0);
    nss_v = 1'b1;
    repeat (8) @(negedge clock);
    do_op("add32_post_rst", 32, 4'h0, 64'h2, 64'h3, 64'h5, 4'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
